sample_capture: RTL and testbench
=================================

Name: sample_capture

Overview:
- Records a burst of signal samples into an internal RAM: arm, wait for trigger, then write consecutive valid samples at incrementing addresses.
- Write-side counterpart to the signal-generator lookup ROM.
- Captured waveforms are read back through a registered, address-in/data-out port with the same one-cycle timing as the ROM.
- Sits after the sample path (e.g. after a delay stage or ADC) for waveform inspection and replay.

Parameters:
- ADDRESS_WIDTH, 8: RAM address width; DEPTH = 2**ADDRESS_WIDTH words.
- DATA_WIDTH, 8: sample width.
- CAPTURE_LEN, 2**ADDRESS_WIDTH: samples per burst. Legal range 1..DEPTH.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  start or restart a capture.
- trig  in  1  trigger; sampled only in ARMED.
- din_valid  in  1  din holds a valid sample this cycle.
- din  in  DATA_WIDTH  sample data.
- rd_addr  in  ADDRESS_WIDTH  readback address.
- dout  out  DATA_WIDTH  registered readback data.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- count  out  ADDRESS_WIDTH+1  samples written in the current burst.

Behaviour:
- Reset (rst=1 at clk edge, overrides all inputs):
  - state=IDLE, wr_ptr=0, count=0, busy=0, done=0, dout=0.
  - RAM contents are not cleared.
- States: IDLE, ARMED, CAPTURE, DONE. busy and done are registered decodes of the state, valid the cycle after entry.
- IDLE:
  - arm=1 -> ARMED; wr_ptr=0, count=0.
  - All other inputs are ignored.
- ARMED:
  - trig=0: no writes.
  - trig=1 -> CAPTURE.
  - If din_valid=1 in the same cycle as trig=1, that din is written at address 0 (wr_ptr->1, count->1).
  - If CAPTURE_LEN=1, trig with din_valid goes directly to DONE.
- CAPTURE:
  - Each cycle with din_valid=1: mem[wr_ptr]<=din, wr_ptr++, count++.
  - din_valid=0: hold.
  - trig is ignored.
  - When the write makes count==CAPTURE_LEN, next state is DONE. No further writes.
- DONE:
  - Holds count=CAPTURE_LEN.
  - din_valid and trig are ignored.
  - arm=1 -> ARMED with wr_ptr=0, count=0, done falls next cycle.
- arm=1 in ARMED or CAPTURE aborts the burst:
  - -> ARMED, wr_ptr=0, count=0.
  - Any write requested in that same cycle is dropped.
  - Arm has priority over trig and din_valid.
- wr_ptr is ADDRESS_WIDTH bits. With CAPTURE_LEN=DEPTH it reaches DEPTH-1 on the last write and never wraps within a burst.
- Readback:
  - dout <= mem[rd_addr] every cycle, in every state including during capture; 1-cycle latency.
  - Read and write to the same address in the same cycle: dout returns the old contents (read-before-write).
- Reset mid-capture: state returns to IDLE. Words already written stay in RAM; the partial burst is not marked done.
- Infers a simple dual-port block RAM (one write port, one synchronous read port). No reset on the memory array.

Test Plan:
- Reset then idle:
  - Assert rst 2 cycles -> busy=0, done=0, count=0, dout=0.
  - din_valid=1 with din=0x55 while in IDLE -> count stays 0; readback of addr 0 shows prior/unknown contents, not 0x55.
- Basic burst (CAPTURE_LEN=4):
  - arm; trig; din_valid for 4 cycles with 0x10,0x20,0x30,0x40 -> done=1, count=4.
  - rd_addr=0..3 -> dout 0x10..0x40, each one cycle after its address.
- Gapped valid plus trig-cycle sample:
  - trig together with din_valid and din=0xA1, then valid gaps, then 0xA2,0xA3,0xA4 -> addresses 0..3 hold A1..A4.
  - count advances only on valid cycles.
- Full depth (CAPTURE_LEN=256):
  - Ramp 0..255 -> done after the 256th write, count=256.
  - Address 255 holds 0xFF; no wrap overwrites address 0.
- Abort and restart:
  - arm after 2 of 4 samples, together with din_valid=1 and din=0xEE -> count=0, state ARMED, 0xEE not written.
  - Re-trigger writes the new data from address 0.
- Read-during-write and reset mid-capture:
  - rd_addr equal to wr_ptr while writing 0x77 over old 0x33 -> dout=0x33 that cycle; 0x77 on a later read.
  - rst during CAPTURE -> busy=0 next cycle; earlier samples still readable.

Source files
------------

// File: rtl/sample_capture.sv
// sample_capture
//   Records a burst of samples into an internal simple dual-port RAM.
//   arm resets the burst pointer and waits for trig; from the trigger
//   cycle on, each valid sample is written at consecutive addresses
//   until CAPTURE_LEN samples are stored. The RAM is read back through
//   a registered address-in/data-out port with one cycle of latency.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | after reset, waiting for arm
//   ARMED   | burst cleared, waiting for trig (trig cycle may write)
//   CAPTURE | writing each valid sample
//   DONE    | CAPTURE_LEN samples stored, waiting for re-arm
//
// Ports
//   clk        clock, all logic on rising edge
//   rst        synchronous active-high reset
//   arm        start/restart a capture (aborts any burst in progress)
//   trig       trigger, looked at only while ARMED
//   din_valid  din carries a valid sample this cycle
//   din        sample data
//   rd_addr    readback address
//   dout       registered readback data (old contents on same-address write)
//   busy       high in ARMED or CAPTURE
//   done       high in DONE
//   count      samples written in the current burst

module sample_capture #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int CAPTURE_LEN   = 2**ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     trig,
    input  logic                     din_valid,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH:0]   count
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] LEN = (ADDRESS_WIDTH+1)'(CAPTURE_LEN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH:0]   count_q, count_d;
    logic                     busy_q, done_q;
    logic                     wr_en;
    logic [DATA_WIDTH-1:0]    dout_q;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    // Next state. arm wins over everything and drops any write in its cycle.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_en    = 1'b0;

        if (arm) begin
            state_d  = S_ARMED;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (trig) begin
                        state_d = S_CAPTURE;
                        wr_en   = din_valid;
                    end
                end
                S_CAPTURE: wr_en = din_valid;
                default: ;
            endcase

            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(1);
                count_d  = count_q + (ADDRESS_WIDTH+1)'(1);
                // Also covers CAPTURE_LEN=1: ARMED goes straight to DONE.
                if (count_d == LEN) begin
                    state_d = S_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            // Decoded from the next state so the flags line up with state_q.
            busy_q   <= (state_d == S_ARMED) || (state_d == S_CAPTURE);
            done_q   <= (state_d == S_DONE);
        end
    end

    // Memory array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Read-before-write: the non-blocking write lands after this read.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= mem[rd_addr];
        end
    end

    assign dout  = dout_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_sample_capture.sv
// Drives two sample_capture instances (CAPTURE_LEN=4 and 256) with the
// same stimulus and compares each against a burst-level reference model.

module tb_sample_capture;

    logic       clk;
    logic       rst, arm, trig, din_valid;
    logic [7:0] din, rd_addr;

    logic [1:0] busy_w, done_w;
    logic [7:0] dout_w  [2];
    logic [8:0] count_w [2];

    int n_err = 0;
    int n_chk = 0;

    sample_capture #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .CAPTURE_LEN(4)) dut_short (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig), .din_valid(din_valid),
        .din(din), .rd_addr(rd_addr), .dout(dout_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .count(count_w[0])
    );

    sample_capture #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .CAPTURE_LEN(256)) dut_full (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig), .din_valid(din_valid),
        .din(din), .rd_addr(rd_addr), .dout(dout_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .count(count_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 waiting for trigger, 2 recording, 3 full.
    int         mlen   [2] = '{4, 256};
    int         mphase [2];
    int         mn     [2];
    logic [7:0] mmem   [2][256];
    bit         mknown [2][256];
    logic [7:0] edout  [2];
    bit         edout_ok [2];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic a, input logic t, input logic v,
                        input logic [7:0] d, input logic [7:0] ra);
        bit wr;
        rst = r; arm = a; trig = t; din_valid = v; din = d; rd_addr = ra;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            edout_ok[i] = mknown[i][ra];
            edout[i]    = mmem[i][ra];
            if (r) begin
                mphase[i] = 0; mn[i] = 0;
                edout[i] = 8'h00; edout_ok[i] = 1'b1;
            end else if (a) begin
                mphase[i] = 1; mn[i] = 0;
            end else begin
                wr = 1'b0;
                if (mphase[i] == 1 && t) begin
                    mphase[i] = 2; wr = v;
                end else if (mphase[i] == 2) begin
                    wr = v;
                end
                if (wr) begin
                    mmem[i][mn[i]]   = d;
                    mknown[i][mn[i]] = 1'b1;
                    mn[i]++;
                    if (mn[i] == mlen[i]) mphase[i] = 3;
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy_len%0d", mlen[i]), int'(busy_w[i]), int'(mphase[i] == 1 || mphase[i] == 2));
            chk($sformatf("done_len%0d", mlen[i]), int'(done_w[i]), int'(mphase[i] == 3));
            chk($sformatf("count_len%0d", mlen[i]), int'(count_w[i]), mn[i]);
            if (edout_ok[i])
                chk($sformatf("dout_len%0d_addr%0h", mlen[i], ra), int'(dout_w[i]), int'(edout[i]));
        end
    endtask

    task automatic rd(input logic [7:0] ra);
        step(0, 0, 0, 0, 8'h00, ra);
    endtask

    initial begin
        logic [7:0] seq [4];
        for (int i = 0; i < 2; i++) begin
            mphase[i] = 0; mn[i] = 0;
            for (int k = 0; k < 256; k++) mknown[i][k] = 1'b0;
        end

        // reset, then stray valids in IDLE are ignored
        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 1, 8'h55, 8'h00);
        step(0, 0, 1, 1, 8'h55, 8'h00);

        // basic burst
        seq = '{8'h10, 8'h20, 8'h30, 8'h40};
        step(0, 1, 0, 0, 8'h00, 8'h00);
        step(0, 0, 1, 0, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, seq[k], 8'h00);
        step(0, 0, 1, 1, 8'h99, 8'h00);
        for (int k = 0; k < 5; k++) rd(8'(k));

        // trigger-cycle sample plus gapped valids
        step(0, 1, 0, 0, 8'h00, 8'h00);
        step(0, 0, 1, 1, 8'hA1, 8'h00);
        step(0, 0, 1, 0, 8'h00, 8'h00);
        step(0, 0, 0, 1, 8'hA2, 8'h00);
        step(0, 0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 1, 8'hA3, 8'h00);
        step(0, 0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 1, 8'hA4, 8'h00);
        for (int k = 0; k < 5; k++) rd(8'(k));

        // abort after two samples, write in the abort cycle dropped
        step(0, 1, 0, 0, 8'h00, 8'h00);
        step(0, 0, 1, 0, 8'h00, 8'h00);
        step(0, 0, 0, 1, 8'hB1, 8'h00);
        step(0, 0, 0, 1, 8'hB2, 8'h00);
        step(0, 1, 1, 1, 8'hEE, 8'h02);
        step(0, 0, 0, 1, 8'hCC, 8'h02);
        step(0, 0, 1, 1, 8'hC1, 8'h02);
        step(0, 0, 0, 1, 8'hC2, 8'h02);
        step(0, 0, 0, 1, 8'hC3, 8'h02);
        step(0, 0, 0, 1, 8'hC4, 8'h02);
        for (int k = 0; k < 5; k++) rd(8'(k));

        // read-during-write returns old contents
        step(0, 1, 0, 0, 8'h00, 8'h00);
        step(0, 0, 1, 1, 8'h33, 8'h00);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 8'h33, 8'h00);
        step(0, 1, 0, 0, 8'h00, 8'h00);
        step(0, 0, 1, 1, 8'h77, 8'h00);
        rd(8'h00);
        rd(8'h00);

        // reset in the middle of a burst
        step(0, 1, 0, 0, 8'h00, 8'h00);
        step(0, 0, 1, 1, 8'h5A, 8'h00);
        step(0, 0, 0, 1, 8'h5B, 8'h00);
        step(1, 0, 0, 1, 8'h5C, 8'h00);
        rd(8'h00);
        rd(8'h01);
        rd(8'h02);

        // full-depth ramp with gaps
        step(0, 1, 0, 0, 8'h00, 8'h00);
        step(0, 0, 1, 0, 8'h00, 8'h00);
        for (int k = 0; k < 256; k++) begin
            if ($urandom_range(0, 3) == 0) step(0, 0, 0, 0, 8'h00, 8'(k));
            step(0, 0, 0, 1, 8'(k), 8'(k));
        end
        step(0, 0, 1, 1, 8'hEE, 8'hFF);
        rd(8'hFF);
        rd(8'h00);
        rd(8'h80);
        rd(8'h03);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom),
                 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
